// File: rtl/im_fetch_seq_if.sv
// im_fetch_seq_if: handshake and fetch-stage bundle for im_fetch_seq.
// master = sequencer side, slave = frame source / fetch stage / downstream side.
interface im_fetch_seq_if #(
  parameter int N_CH = 4,
  parameter int QW   = 4,
  parameter int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N_CH*QW-1:0]   in_qlevels;
  logic                 fetch_en;
  logic [3:0]           fetch_qlevel;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_ch;
  logic                 out_last;
  logic                 frame_done;
  logic                 busy;
  logic                 err_qlevel;
  logic [7:0]           err_count;
  modport master (
    input  in_valid, in_qlevels, out_ready,
    output in_ready, fetch_en, fetch_qlevel, out_valid, out_ch, out_last,
           frame_done, busy, err_qlevel, err_count
  );
  modport slave (
    output in_valid, in_qlevels, out_ready,
    input  in_ready, fetch_en, fetch_qlevel, out_valid, out_ch, out_last,
           frame_done, busy, err_qlevel, err_count
  );
endinterface

// File: rtl/im_fetch_seq.sv
// im_fetch_seq: item-memory fetch sequencer; walks a latched frame of levels one channel at a time.
// Ports: clk, nrst (sync, active-low), bus (im_fetch_seq_if.master: frame in, fetch en/qlevel, HV present, done/err).
// Macro IM_FETCH_RANGE_CHECK_EN: skip channels whose level is 0 or above N_LEVELS and count them.
module im_fetch_seq #(
  parameter int N_CH     = 4,
  parameter int QW       = 4,
  parameter int N_LEVELS = 10,
  parameter int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input logic            clk,
  input logic            nrst,
  im_fetch_seq_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;
  state_t             state, state_nx;
  logic [CW-1:0]      ch, ch_nx;
  logic [N_CH*QW-1:0] frame_buf;
  logic [QW-1:0]      qcur;
  logic               last, bad, fetching;
  if (N_CH < 1 || N_LEVELS < 1) begin : g_bad_params
    $error("im_fetch_seq: N_CH and N_LEVELS must be at least 1");
  end
  assign qcur = frame_buf[ch*QW +: QW];
  assign last = ch == CW'(N_CH - 1);
`ifdef IM_FETCH_RANGE_CHECK_EN
  logic       err_q;
  logic [7:0] err_cnt;
  assign bad = qcur == '0 || 32'(qcur) > N_LEVELS;
  always_ff @(posedge clk)
    if (!nrst) begin
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else if (state == FETCH && bad) begin
      err_q   <= 1'b1;
      err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
    end
  assign bus.err_qlevel = nrst & err_q;
  assign bus.err_count  = nrst ? err_cnt : '0;
`else
  assign bad            = 1'b0;
  assign bus.err_qlevel = 1'b0;
  assign bus.err_count  = '0;
`endif
  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    unique case (state)
      IDLE:    if (bus.in_valid) begin
                 state_nx = FETCH;
                 ch_nx    = '0;
               end
      FETCH:   if (bad) begin
                 state_nx = last ? DONE : FETCH;
                 ch_nx    = last ? ch : ch + 1'b1;
               end else state_nx = PRESENT;
      PRESENT: if (bus.out_ready) begin
                 state_nx = last ? DONE : FETCH;
                 ch_nx    = last ? ch : ch + 1'b1;
               end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!nrst) begin
      state     <= IDLE;
      ch        <= '0;
      frame_buf <= '0;
    end else begin
      state <= state_nx;
      ch    <= ch_nx;
      if (state == IDLE && bus.in_valid) frame_buf <= bus.in_qlevels;
    end
  // Every output is forced low while nrst is asserted, independent of the registered state.
  assign fetching         = nrst & ((state == FETCH & ~bad) | state == PRESENT);
  assign bus.fetch_en     = fetching;
  assign bus.fetch_qlevel = fetching ? 4'(qcur) : 4'd0;
  assign bus.out_valid    = nrst & state == PRESENT;
  assign bus.out_ch       = bus.out_valid ? ch : '0;
  assign bus.out_last     = bus.out_valid & last;
  assign bus.frame_done   = nrst & state == DONE;
  assign bus.busy         = nrst & state != IDLE;
  assign bus.in_ready     = nrst & state == IDLE;
endmodule

// File: tb/tb_im_fetch_seq.sv
// tb_im_fetch_seq: randomized frames checked against a channel-list reference model.
module tb_im_fetch_seq;
`ifdef IM_FETCH_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int checks = 0;
  int errors = 0;
  int err_cnt_exp = 0;
  bit err_q_exp = 1'b0;
  im_fetch_seq_if #(.N_CH(4), .QW(4)) bus();
  im_fetch_seq #(.N_CH(4), .QW(4), .N_LEVELS(10)) dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_zero"}, {bus.in_ready, bus.fetch_en, bus.fetch_qlevel, bus.out_valid, bus.out_ch,
                           bus.out_last, bus.frame_done, bus.busy, bus.err_qlevel, bus.err_count}, 0);
  endtask
  // mode: 0 = out_ready always high, 1 = random backpressure, 2 = 5 stall cycles on ch 1
  task automatic run_frame(input logic [15:0] q, input int mode);
    int exp_ch[$];
    int exp_q[$];
    int nskip = 0, npres = 0, stalls = 0, st = 0, cyc;
    bit done = 1'b0, first0;
    for (int c = 0; c < 4; c++) begin
      int lv = int'(q[c*4 +: 4]);
      if (RANGE_EN && (lv == 0 || lv > 10)) nskip++;
      else begin
        exp_ch.push_back(c);
        exp_q.push_back(lv);
        npres++;
      end
    end
    first0 = npres > 0 && exp_ch[0] == 0;
    @(negedge clk);
    check("idle_ready", bus.in_ready, 1);
    check("idle_done", bus.frame_done, 0);
    bus.in_qlevels = q;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_qlevels = 16'($urandom);
    cyc = 1;
    while (!done && cyc < 200) begin
      check("ready_busy", bus.in_ready, 0);
      check("busy", bus.busy, 1);
      if (cyc == 2 && first0) check("first_valid", bus.out_valid, 1);
      bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) :
                      (bus.out_valid && bus.out_ch == 1 && st < 5) ? 1'b0 : 1'b1;
      if (bus.frame_done) begin
        check("done_cycles", cyc, 2 * npres + nskip + stalls + 1);
        check("done_left", exp_ch.size(), 0);
        done = 1'b1;
      end else if (bus.out_valid) begin
        if (exp_ch.size() == 0) check("extra_valid", bus.out_valid, 0);
        else begin
          check("out_ch", bus.out_ch, exp_ch[0]);
          check("qlevel", bus.fetch_qlevel, exp_q[0]);
          check("fetch_en", bus.fetch_en, 1);
          check("out_last", bus.out_last, exp_ch[0] == 3);
          if (bus.out_ready) begin
            void'(exp_ch.pop_front());
            void'(exp_q.pop_front());
            st = 0;
          end else begin
            stalls++;
            st++;
          end
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) check("done_timeout", 0, 1);
    if (mode == 2 && npres == 4) check("stall_cycles", cyc, 14);
    if (mode == 0 && npres == 4) check("frame_cycles", cyc, 9);
    err_cnt_exp = err_cnt_exp + nskip > 255 ? 255 : err_cnt_exp + nskip;
    if (nskip > 0) err_q_exp = 1'b1;
    check("err_count", bus.err_count, err_cnt_exp);
    check("err_qlevel", bus.err_qlevel, err_q_exp);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_qlevels = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    nrst = 1'b1;
    run_frame(16'h3A51, 0);
    run_frame(16'h3A51, 2);
    run_frame(16'h7C40, 0);
    run_frame(16'h2345, 1);
    for (int i = 0; i < 20; i++) run_frame(16'($urandom), 1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("idle_ready2", bus.in_ready, 1);
    bus.in_qlevels = 16'h2345;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !(bus.out_valid && bus.out_ch == 2); i++) @(negedge clk);
    check("reach_ch2", bus.out_valid && bus.out_ch == 2, 1);
    bus.out_ready = 1'b0;
    nrst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    nrst = 1'b1;
    err_cnt_exp = 0;
    err_q_exp = 1'b0;
    @(negedge clk);
    check("post_reset_ready", bus.in_ready, 1);
    check("post_reset_valid", bus.out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_done_after_reset", bus.frame_done, 0);
    end
    run_frame(16'h7C40, 1);
    for (int i = 0; i < 128; i++) run_frame(16'h7C40, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/im_fetch_seq.md
# im_fetch_seq

Sequencer that drives the item-memory fetch stage of the sparse HDC encoder. Accepts one frame of per-channel quantized levels over a valid/ready handshake and, for each channel in turn, drives the fetch enable and level select of the level-HV mux. It then presents the fetched level hypervector's channel index to the downstream bind/bundle stage and signals end-of-frame. It is the only master of the fetch stage's `en`/`qlevel` inputs.

## Interface
Parameters:
- `N_CH`, 4: channels per frame (≥1)
- `QW`, 4: bits per quantized level
- `N_LEVELS`, 10: highest valid level; valid range is 1..N_LEVELS
- `CW`, $clog2(N_CH) (min 1): channel index width

Ports:
- `clk` in 1: clock, rising edge
- `nrst` in 1: reset, synchronous, active-low
- `in_valid` in 1: frame available
- `in_ready` out 1: sequencer can accept a frame
- `in_qlevels` in N_CH*QW: channel c at bits [c*QW +: QW]
- `fetch_en` out 1: to fetch stage `en`
- `fetch_qlevel` out 4: to fetch stage `qlevel`
- `out_valid` out 1: fetched HV on the fetch output is stable for channel `out_ch`
- `out_ready` in 1: downstream consumed it
- `out_ch` out CW: channel index of the presented HV
- `out_last` out 1: presented channel is the last of the frame
- `frame_done` out 1: one-cycle pulse after the frame completes
- `busy` out 1: state ≠ IDLE
- `err_qlevel` out 1: sticky out-of-range flag (macro only)
- `err_count` out 8: saturating count of skipped channels (macro only)

## Operation
- FSM states: IDLE, FETCH, PRESENT, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`, latch `in_qlevels` into the frame buffer, set ch=0, go to FETCH.
- FETCH: `fetch_en`=1, `fetch_qlevel`=buf[ch]. Next state is PRESENT. This cycle is a bubble for the wide mux path.
- PRESENT: `fetch_en`=1 and `fetch_qlevel` are held so the fetch output stays stable. `out_valid`=1, `out_ch`=ch, `out_last`=(ch==N_CH-1).
  - On `out_ready`: if last, go to DONE; otherwise ch++ and go to FETCH.
  - Without `out_ready`: stay in PRESENT with all outputs held (backpressure, unlimited).
- DONE: `frame_done`=1 for exactly one cycle, then IDLE.
- Outside FETCH/PRESENT: `fetch_en`=0 and `fetch_qlevel`=0. The fetch stage holds its last value.
- `in_ready` is 0 in every state except IDLE. A new frame is never accepted while busy.
- The frame buffer is not altered by `in_qlevels` changes after acceptance.

## Timing
- Reset (`nrst`=0 at an edge): state goes to IDLE; buffer, ch, `err_qlevel` and `err_count` are cleared.
  - While `nrst`=0, all outputs are 0, including `in_ready`.
  - `in_ready`=1 on the first cycle after `nrst` rises.
- Reset mid-frame aborts the frame immediately. No `frame_done` is produced and no further `out_valid` is asserted.
- Handshake at edge T0 leads to FETCH in cycle T0+1, with `out_valid` first high in T0+2.
- Each channel takes 2 cycles with `out_ready` held high.
- Full frame with no backpressure takes 2·N_CH+1 cycles from accept to `frame_done`. The next accept is possible in the cycle after `frame_done`.
- `frame_done` and `in_ready` are never high in the same cycle.
- ch is CW bits wide and is never incremented past N_CH-1 (no wrap).

## Configuration
- `IM_FETCH_RANGE_CHECK_EN` defined:
  - In FETCH, if buf[ch]==0 or buf[ch]>N_LEVELS, the channel is skipped: no PRESENT, `fetch_en`=0 that cycle.
  - On a skip, `err_qlevel` is set (sticky until reset) and `err_count` increments, saturating at 255.
  - After a skip, the sequencer moves to FETCH of ch+1, or to DONE if the skipped channel was last.
  - A frame with every channel skipped still produces `frame_done`, with no `out_valid`.
- Not defined: every channel is presented regardless of value (the fetch stage outputs zero for out-of-range levels). `err_qlevel` and `err_count` are tied to 0.

## Test plan
- Reset, then frame {1,5,10,3} with N_CH=4 and `out_ready`=1:
  - `fetch_qlevel` sequence is 1,5,10,3.
  - `out_ch` is 0..3; `out_last` is high only with ch=3.
  - `frame_done` occurs 9 cycles after accept.
- Same frame with `out_ready` low for 5 cycles on ch=1:
  - `out_valid`, `out_ch`=1 and `fetch_qlevel`=5 are held stable for 6 cycles.
  - No `frame_done` before ch=3 is consumed.
- `in_valid` held high continuously with two different frames:
  - Second frame is accepted only in the cycle after `frame_done`.
  - `in_ready` is 0 throughout the first frame.
- `nrst` pulled low while in PRESENT on ch=2:
  - Next cycle all outputs are 0; no `frame_done`.
  - `in_ready`=1 one cycle after release.
- With `IM_FETCH_RANGE_CHECK_EN`, frame {0,4,12,7}:
  - Only ch 1 and 3 are presented.
  - `err_qlevel`=1 and `err_count`=2.
  - Repeating the frame 128 times saturates `err_count` at 255.
- Without the macro, the same frame {0,4,12,7} presents all 4 channels and `err_count` stays 0.
